ttl_shift_bank: RTL and testbench
=================================

Name: ttl_shift_bank

Overview:
- Parametrised multi-channel universal shift register bank.
- Combines 74LS194/299-style mode control (hold, shift up, shift down, parallel load) with 74LS166-style video serialisation, generalised to CHANNELS lanes of WIDTH bits.
- Adds clock enable, a shift counter, and auto-reload every WIDTH shifts.
- Sits between tile/sprite ROM data and the colour mux in the video path; also usable as a generic cascadable shifter.

Parameters:
- CHANNELS, 3, number of independent lanes sharing mode, counter and control.
- WIDTH, 8, bits per lane; legal range 2..32.
- CNT_W, $clog2(WIDTH), shift counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds.
- mode  in  2  S1:S0. 00 hold; 01 shift up (toward MSB); 10 shift down (toward LSB); 11 parallel load.
- auto_en  in  1  enables auto-reload at end of word.
- pin  in  CHANNELS*WIDTH  parallel data; lane c at [c*WIDTH +: WIDTH].
- dsr  in  CHANNELS  serial input per lane for shift up (enters bit 0).
- dsl  in  CHANNELS  serial input per lane for shift down (enters bit WIDTH-1).
- q_lo  out  CHANNELS  bit 0 of each lane.
- q_hi  out  CHANNELS  bit WIDTH-1 of each lane.
- q_par  out  CHANNELS*WIDTH  full register contents.
- bit_cnt  out  CNT_W  shifts since last load.
- loaded  out  1  one-clk pulse after any load.

Behaviour:
- Reset: all lane registers 0, bit_cnt 0, loaded 0. Outputs are pure decodes of state, so q_lo, q_hi and q_par are 0. Reset overrides ce and mode.
- ce=0: registers and bit_cnt hold; loaded is forced 0 on that edge. loaded is therefore a single-clk pulse even under a slow ce.
- ce=1, mode 00: hold; loaded 0.
- ce=1, mode 11: every lane loads pin; bit_cnt becomes 0; loaded becomes 1 next cycle.
- ce=1, mode 01: lane becomes {reg[WIDTH-2:0], dsr[c]}.
- ce=1, mode 10: lane becomes {dsl[c], reg[WIDTH-1:1]}.
- Shift counting with auto_en=0: bit_cnt increments per shift and saturates at WIDTH-1 (no wrap).
- Auto-reload (auto_en=1, mode 01 or 10, bit_cnt==WIDTH-1): the edge performs a parallel load instead of a shift; bit_cnt becomes 0; loaded pulses. This gives a reload every WIDTH ce-cycles.
- Priority: reset > ce=0 > mode 11 > auto-reload > shift > hold.
- Mid-word direction change: bit_cnt keeps counting; there is no reset on direction change.
- Latency: serial outputs are registered-state decodes, so new q_lo/q_hi are visible the cycle after the causing edge.
- WIDTH non-power-of-2: bit_cnt never exceeds WIDTH-1.

Optional Feature:
- Macro: TTL_SHIFT_BANK_FLIP_EN.
- With the macro defined: extra input port flip (1 bit). On any load (manual or auto) with flip=1, each lane loads the bit-reversed pin slice, giving horizontal sprite flip. With flip=0, behaviour is unchanged.
- Without the macro: port flip is absent; loads are always straight.

Decomposition:
- Shared package ttl_pkg holds mode constants: MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11.
- One sub-module, ttl_shift_lane: a single WIDTH-bit register with decoded load/up/down/hold controls (and optional flip), instantiated CHANNELS times by generate.
- Counter, auto-reload decision and loaded pulse live in the top module only.

Test Plan:
- Reset: assert reset 2 cycles with mode=11 and pin all-ones -> q_par=0, bit_cnt=0, loaded=0.
- Shift down: load lane0=8'hA5, then mode=10, dsl=0 for 8 cycles -> q_lo sequence 1,0,1,0,0,1,0,1; q_par lane0=0 after the 8th shift; bit_cnt saturates at 7.
- Auto-reload: auto_en=1, mode=01; load lane1=8'h81, pin changed to 8'h3C -> q_hi sequence 1,0,0,0,0,0,0,1; 8th edge loads 8'h3C; loaded pulses exactly every 8 clk cycles.
- Clock enable: ce alternates 1/0 during mode=01 -> q_hi changes only on ce=1 edges; bit_cnt reaches 7 after 14 clk cycles; loaded width is 1 clk.
- Reset mid-shift: at bit_cnt=4, pulse reset with mode=11 -> next cycle q_par=0, bit_cnt=0, loaded=0 (no load performed).
- Flip (macro defined): load 8'h01 with flip=1 -> q_par lane=8'h80; with flip=0 -> 8'h01; auto-reload also honours flip.

Source files
------------

// File: rtl/ttl_pkg.sv
// ttl_pkg: shared constants for the TTL-style shift register bank.
//   MODE_* : S1:S0 mode encodings (hold, shift up, shift down, parallel load).
package ttl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/ttl_shift_lane.sv
// ttl_shift_lane: one WIDTH-bit universal shift register lane.
// Controls arrive already decoded and qualified by clock enable. At most one of
// load/shift_up/shift_down is set in a cycle. With none of them set, the lane holds.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset (clears the register)
//   load       parallel load of pin (bit-reversed when flip=1)
//   shift_up   shift toward MSB, dsr enters bit 0
//   shift_down shift toward LSB, dsl enters bit WIDTH-1
//   flip       bit-reverse the loaded data
//   pin        parallel data
//   dsr, dsl   serial inputs
//   q          register contents
module ttl_shift_lane #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_up,
    input  logic             shift_down,
    input  logic             flip,
    input  logic [WIDTH-1:0] pin,
    input  logic             dsr,
    input  logic             dsl,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] reg_q, reg_d;
    logic [WIDTH-1:0] pin_rev;

    always_comb begin
        pin_rev = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pin_rev[i] = pin[WIDTH-1-i];
        end
    end

    always_comb begin
        reg_d = reg_q;
        if (load) begin
            reg_d = flip ? pin_rev : pin;
        end else if (shift_up) begin
            reg_d = {reg_q[WIDTH-2:0], dsr};
        end else if (shift_down) begin
            reg_d = {dsl, reg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/ttl_shift_bank.sv
// ttl_shift_bank: CHANNELS-lane universal shift register bank with clock enable,
// shared shift counter and auto-reload every WIDTH shifts (video serialiser).
// Optional feature macro: TTL_SHIFT_BANK_FLIP_EN adds input 'flip' which
// bit-reverses every load (manual or auto) for horizontal sprite flip.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset, overrides everything
//   ce       clock enable; low holds all state and clears loaded
//   mode     00 hold, 01 shift up, 10 shift down, 11 parallel load
//   auto_en  reload from pin instead of shifting once bit_cnt reaches WIDTH-1
//   flip     (macro only) bit-reverse loaded data
//   pin      parallel data, lane c at [c*WIDTH +: WIDTH]
//   dsr/dsl  per-lane serial inputs for shift up / shift down
//   q_lo     bit 0 of each lane
//   q_hi     bit WIDTH-1 of each lane
//   q_par    full register contents
//   bit_cnt  shifts since last load, saturating at WIDTH-1
//   loaded   one-clock pulse after any load
module ttl_shift_bank
    import ttl_pkg::*;
#(
    parameter  int unsigned CHANNELS = 3,
    parameter  int unsigned WIDTH    = 8,
    localparam int unsigned CNT_W    = $clog2(WIDTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic [1:0]                mode,
    input  logic                      auto_en,
`ifdef TTL_SHIFT_BANK_FLIP_EN
    input  logic                      flip,
`endif
    input  logic [CHANNELS*WIDTH-1:0] pin,
    input  logic [CHANNELS-1:0]       dsr,
    input  logic [CHANNELS-1:0]       dsl,
    output logic [CHANNELS-1:0]       q_lo,
    output logic [CHANNELS-1:0]       q_hi,
    output logic [CHANNELS*WIDTH-1:0] q_par,
    output logic [CNT_W-1:0]          bit_cnt,
    output logic                      loaded
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loaded_q, loaded_d;
    logic             shift_req, cnt_full;
    logic             do_load, do_up, do_down;
    logic             flip_int;

`ifdef TTL_SHIFT_BANK_FLIP_EN
    assign flip_int = flip;
`else
    assign flip_int = 1'b0;
`endif

    // Decode: manual load beats auto-reload, which replaces the shift it would have done.
    always_comb begin
        shift_req = ce && ((mode == MODE_UP) || (mode == MODE_DOWN));
        cnt_full  = (cnt_q == CNT_W'(WIDTH - 1));
        do_load   = ce && ((mode == MODE_LOAD) || (auto_en && shift_req && cnt_full));
        do_up     = ce && (mode == MODE_UP) && !do_load;
        do_down   = ce && (mode == MODE_DOWN) && !do_load;

        cnt_d = cnt_q;
        if (do_load) begin
            cnt_d = '0;
        end else if ((do_up || do_down) && !cnt_full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // ce=0 yields 0 here, so the pulse stays one clk wide under a slow ce.
        loaded_d = do_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_lane
        ttl_shift_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (do_load),
            .shift_up  (do_up),
            .shift_down(do_down),
            .flip      (flip_int),
            .pin       (pin[c*WIDTH +: WIDTH]),
            .dsr       (dsr[c]),
            .dsl       (dsl[c]),
            .q         (q_par[c*WIDTH +: WIDTH])
        );

        assign q_lo[c] = q_par[c*WIDTH];
        assign q_hi[c] = q_par[c*WIDTH + WIDTH - 1];
    end

    assign bit_cnt = cnt_q;
    assign loaded  = loaded_q;

endmodule

// File: tb/tb_ttl_shift_bank.sv
// Directed self-checking bench for ttl_shift_bank (CHANNELS=3, WIDTH=8).
// Define TTL_SHIFT_BANK_FLIP_EN for both bench and RTL to exercise flip.
module tb_ttl_shift_bank;

    localparam int unsigned CH = 3;
    localparam int unsigned W  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic [1:0]    mode;
    logic          auto_en;
    logic          flip;
    logic [CH*W-1:0] pin;
    logic [CH-1:0] dsr;
    logic [CH-1:0] dsl;
    logic [CH-1:0] q_lo;
    logic [CH-1:0] q_hi;
    logic [CH*W-1:0] q_par;
    logic [2:0]    bit_cnt;
    logic          loaded;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ttl_shift_bank #(
        .CHANNELS(CH),
        .WIDTH   (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .mode   (mode),
        .auto_en(auto_en),
`ifdef TTL_SHIFT_BANK_FLIP_EN
        .flip   (flip),
`endif
        .pin    (pin),
        .dsr    (dsr),
        .dsl    (dsl),
        .q_lo   (q_lo),
        .q_hi   (q_hi),
        .q_par  (q_par),
        .bit_cnt(bit_cnt),
        .loaded (loaded)
    );

    // Advance one rising edge; outputs are then sampled and inputs changed 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; mode = 2'b11; pin = '1;
        step(); step();
        n_checks++;
        if (q_par !== '0) begin n_fail++; $display("FAIL reset_q_par got %h want 0", q_par); end
        n_checks++;
        if (bit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); end
        n_checks++;
        if (loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded got %b want 0", loaded); end
        reset = 1'b0; mode = 2'b00;
        step();
        n_checks++;
        if (q_par !== '0) begin n_fail++; $display("FAIL reset_hold got %h want 0", q_par); end
    endtask

    task automatic test_shift_down();
        logic [7:0] seq;
        logic [2:0] cnt_exp;
        seq = 8'hA5;
        pin = {8'h00, 8'h00, 8'hA5}; mode = 2'b11; auto_en = 1'b0; dsl = '0; dsr = '0;
        step();
        n_checks++;
        if (q_par[7:0] !== 8'hA5) begin n_fail++; $display("FAIL sd_load got %h want a5", q_par[7:0]); end
        n_checks++;
        if (loaded !== 1'b1) begin n_fail++; $display("FAIL sd_loaded got %b want 1", loaded); end
        mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (q_lo[0] !== seq[i]) begin
                n_fail++; $display("FAIL sd_q_lo[%0d] got %b want %b", i, q_lo[0], seq[i]);
            end
            step();
            cnt_exp = (i >= 6) ? 3'd7 : 3'(i + 1);
            n_checks++;
            if (bit_cnt !== cnt_exp) begin
                n_fail++; $display("FAIL sd_bit_cnt[%0d] got %0d want %0d", i, bit_cnt, cnt_exp);
            end
            n_checks++;
            if (loaded !== 1'b0) begin n_fail++; $display("FAIL sd_loaded_low[%0d] got 1 want 0", i); end
        end
        n_checks++;
        if (q_par[7:0] !== 8'h00) begin n_fail++; $display("FAIL sd_empty got %h want 00", q_par[7:0]); end
    endtask

    task automatic test_auto_reload();
        logic [7:0] seq;
        logic [7:0] exp_lane;
        logic       exp_ld;
        seq = 8'h81;
        pin = {8'h00, 8'h81, 8'h00}; mode = 2'b11; auto_en = 1'b1; dsr = '0;
        step();
        n_checks++;
        if (q_par[15:8] !== 8'h81) begin n_fail++; $display("FAIL ar_load got %h want 81", q_par[15:8]); end
        pin = {8'h00, 8'h3C, 8'h00}; mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (q_hi[1] !== seq[i]) begin
                n_fail++; $display("FAIL ar_q_hi[%0d] got %b want %b", i, q_hi[1], seq[i]);
            end
            step();
        end
        n_checks++;
        if (q_par[15:8] !== 8'h3C) begin n_fail++; $display("FAIL ar_reload got %h want 3c", q_par[15:8]); end
        n_checks++;
        if (loaded !== 1'b1) begin n_fail++; $display("FAIL ar_loaded got %b want 1", loaded); end
        n_checks++;
        if (bit_cnt !== 3'd0) begin n_fail++; $display("FAIL ar_bit_cnt got %0d want 0", bit_cnt); end
        exp_lane = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_ld   = (i % 8) == 7;
            exp_lane = exp_ld ? 8'h3C : {exp_lane[6:0], 1'b0};
            n_checks++;
            if (loaded !== exp_ld) begin
                n_fail++; $display("FAIL ar_period[%0d] got %b want %b", i, loaded, exp_ld);
            end
            n_checks++;
            if (q_par[15:8] !== exp_lane) begin
                n_fail++; $display("FAIL ar_lane[%0d] got %h want %h", i, q_par[15:8], exp_lane);
            end
        end
        auto_en = 1'b0; mode = 2'b00;
    endtask

    task automatic test_clock_enable();
        int         shifts;
        logic [7:0] exp_lane;
        pin = {8'h01, 8'h00, 8'h00}; mode = 2'b11; auto_en = 1'b0; ce = 1'b1; dsr = '0;
        step();
        n_checks++;
        if (loaded !== 1'b1) begin n_fail++; $display("FAIL ce_loaded got %b want 1", loaded); end
        mode   = 2'b01;
        shifts = 0;
        for (int i = 0; i < 14; i++) begin
            ce = (i % 2) == 1;
            step();
            if (ce) shifts++;
            exp_lane = 8'h01 << shifts;
            n_checks++;
            if (q_par[23:16] !== exp_lane) begin
                n_fail++; $display("FAIL ce_lane[%0d] got %h want %h", i, q_par[23:16], exp_lane);
            end
            n_checks++;
            if (q_hi[2] !== exp_lane[7]) begin
                n_fail++; $display("FAIL ce_q_hi[%0d] got %b want %b", i, q_hi[2], exp_lane[7]);
            end
            n_checks++;
            if (loaded !== 1'b0) begin n_fail++; $display("FAIL ce_pulse[%0d] got 1 want 0", i); end
        end
        n_checks++;
        if (bit_cnt !== 3'd7) begin n_fail++; $display("FAIL ce_bit_cnt got %0d want 7", bit_cnt); end
        ce = 1'b1; mode = 2'b00;
    endtask

    task automatic test_hold();
        pin = {8'h12, 8'h34, 8'h56}; mode = 2'b11; ce = 1'b1;
        step();
        mode = 2'b00;
        step(); step();
        n_checks++;
        if (q_par !== 24'h123456) begin n_fail++; $display("FAIL hold_q_par got %h want 123456", q_par); end
        n_checks++;
        if (loaded !== 1'b0) begin n_fail++; $display("FAIL hold_loaded got 1 want 0"); end
        ce = 1'b0; mode = 2'b11; pin = 24'hABCDEF;
        step();
        n_checks++;
        if (q_par !== 24'h123456) begin n_fail++; $display("FAIL ce0_noload got %h want 123456", q_par); end
        n_checks++;
        if (loaded !== 1'b0) begin n_fail++; $display("FAIL ce0_loaded got 1 want 0"); end
        ce = 1'b1; mode = 2'b00;
    endtask

    task automatic test_reset_mid_shift();
        pin = '1; mode = 2'b11; ce = 1'b1; auto_en = 1'b0; dsr = '1;
        step();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (bit_cnt !== 3'd4) begin n_fail++; $display("FAIL rm_pre_cnt got %0d want 4", bit_cnt); end
        reset = 1'b1; mode = 2'b11;
        step();
        n_checks++;
        if (q_par !== '0) begin n_fail++; $display("FAIL rm_q_par got %h want 0", q_par); end
        n_checks++;
        if (bit_cnt !== 3'd0) begin n_fail++; $display("FAIL rm_bit_cnt got %0d want 0", bit_cnt); end
        n_checks++;
        if (loaded !== 1'b0) begin n_fail++; $display("FAIL rm_loaded got 1 want 0"); end
        reset = 1'b0; mode = 2'b00; dsr = '0;
        step();
        n_checks++;
        if (loaded !== 1'b0) begin n_fail++; $display("FAIL rm_after got 1 want 0"); end
    endtask

`ifdef TTL_SHIFT_BANK_FLIP_EN
    task automatic test_flip();
        pin = {8'h01, 8'h01, 8'h01}; mode = 2'b11; flip = 1'b1; auto_en = 1'b0;
        step();
        n_checks++;
        if (q_par !== 24'h808080) begin n_fail++; $display("FAIL flip_on got %h want 808080", q_par); end
        flip = 1'b0;
        step();
        n_checks++;
        if (q_par !== 24'h010101) begin n_fail++; $display("FAIL flip_off got %h want 010101", q_par); end
        pin = {8'h00, 8'h00, 8'h03}; flip = 1'b1; mode = 2'b01; auto_en = 1'b1; dsr = '0;
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (q_par[7:0] !== 8'hC0) begin n_fail++; $display("FAIL flip_auto got %h want c0", q_par[7:0]); end
        flip = 1'b0; auto_en = 1'b0; mode = 2'b00;
    endtask
`endif

    initial begin
        reset = 1'b1; ce = 1'b1; mode = 2'b00; auto_en = 1'b0; flip = 1'b0;
        pin = '0; dsr = '0; dsl = '0;
        #1;
        test_reset();
        test_shift_down();
        test_auto_reload();
        test_clock_enable();
        test_hold();
        test_reset_mid_shift();
`ifdef TTL_SHIFT_BANK_FLIP_EN
        test_flip();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
